ysyx_22041207_rd_arb: RTL and testbench

YSYX_22041207_RD_ARB -- requirements
Module: ysyx_22041207_rd_arb

---
 rtl/ysyx_22041207_rd_arb_if.sv | 50 +++++
 rtl/ysyx_22041207_rd_arb.sv | 113 +++++++++++
 tb/tb_ysyx_22041207_rd_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_rd_arb_if.sv
// Bus bundle for the two-requester read arbiter: IF/LSU request and data
// channels plus the single downstream read port.
interface ysyx_22041207_rd_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              m0_r_valid_i;
    logic              m0_r_ready_o;
    logic [ADDR_W-1:0] m0_r_addr_i;
    logic [7:0]        m0_r_size_i;
    logic [DATA_W-1:0] m0_data_read_o;
    logic              m0_data_valid;
    logic              m0_data_ready;

    logic              m1_r_valid_i;
    logic              m1_r_ready_o;
    logic [ADDR_W-1:0] m1_r_addr_i;
    logic [7:0]        m1_r_size_i;
    logic [DATA_W-1:0] m1_data_read_o;
    logic              m1_data_valid;
    logic              m1_data_ready;

    logic              s_r_valid;
    logic              s_r_ready;
    logic [ADDR_W-1:0] s_r_addr;
    logic [7:0]        s_r_size;
    logic [DATA_W-1:0] s_data_read;
    logic              s_data_valid;
    logic              s_data_ready;

    // Environment side: requesters and downstream memory.
    modport master (
        output m0_r_valid_i, m0_r_addr_i, m0_r_size_i, m0_data_ready,
        output m1_r_valid_i, m1_r_addr_i, m1_r_size_i, m1_data_ready,
        output s_r_ready, s_data_read, s_data_valid,
        input  m0_r_ready_o, m0_data_read_o, m0_data_valid,
        input  m1_r_ready_o, m1_data_read_o, m1_data_valid,
        input  s_r_valid, s_r_addr, s_r_size, s_data_ready
    );

    // Arbiter side.
    modport slave (
        input  m0_r_valid_i, m0_r_addr_i, m0_r_size_i, m0_data_ready,
        input  m1_r_valid_i, m1_r_addr_i, m1_r_size_i, m1_data_ready,
        input  s_r_ready, s_data_read, s_data_valid,
        output m0_r_ready_o, m0_data_read_o, m0_data_valid,
        output m1_r_ready_o, m1_data_read_o, m1_data_valid,
        output s_r_valid, s_r_addr, s_r_size, s_data_ready
    );
endinterface

// File: rtl/ysyx_22041207_rd_arb.sv
// Two-requester read arbiter: one outstanding transaction, round-robin on
// contention, IDLE -> ADDR -> DATA per transaction.
module ysyx_22041207_rd_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22041207_rd_arb_if.slave  bus,
    output logic [1:0]             gnt,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        size_q;
    logic              win;
    logic              grant;
    logic              beat_done;

    // On contention the requester that did not own the last transaction wins.
    assign win = (bus.m0_r_valid_i && bus.m1_r_valid_i) ? ~last_gnt_q : bus.m1_r_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= win;
                addr_q  <= win ? bus.m1_r_addr_i : bus.m0_r_addr_i;
                size_q  <= win ? bus.m1_r_size_i : bus.m0_r_size_i;
            end
            if (beat_done) last_gnt_q <= owner_q;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant              = 1'b0;
        beat_done          = 1'b0;
        bus.m0_r_ready_o   = 1'b0;
        bus.m1_r_ready_o   = 1'b0;
        bus.m0_data_valid  = 1'b0;
        bus.m1_data_valid  = 1'b0;
        bus.m0_data_read_o = '0;
        bus.m1_data_read_o = '0;
        bus.s_r_valid      = 1'b0;
        bus.s_r_addr       = '0;
        bus.s_r_size       = '0;
        bus.s_data_ready   = 1'b0;
        busy               = (state_q != IDLE);
        gnt                = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.m0_r_valid_i || bus.m1_r_valid_i) begin
                    grant            = 1'b1;
                    state_d          = ADDR;
                    bus.m0_r_ready_o = ~win;
                    bus.m1_r_ready_o = win;
                end
            end
            ADDR: begin
                gnt           = owner_q ? 2'b10 : 2'b01;
                bus.s_r_valid = 1'b1;
                bus.s_r_addr  = addr_q;
                bus.s_r_size  = size_q;
                if (bus.s_r_ready) state_d = DATA;
            end
            DATA: begin
                gnt = owner_q ? 2'b10 : 2'b01;
                if (owner_q) begin
                    bus.s_data_ready   = bus.m1_data_ready;
                    bus.m1_data_valid  = bus.s_data_valid;
                    bus.m1_data_read_o = bus.s_data_read;
                end else begin
                    bus.s_data_ready   = bus.m0_data_ready;
                    bus.m0_data_valid  = bus.s_data_valid;
                    bus.m0_data_read_o = bus.s_data_read;
                end
                beat_done = bus.s_data_valid && bus.s_data_ready;
                if (beat_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every output immediately, aborting any beat in flight.
        if (rst) begin
            grant              = 1'b0;
            beat_done          = 1'b0;
            bus.m0_r_ready_o   = 1'b0;
            bus.m1_r_ready_o   = 1'b0;
            bus.m0_data_valid  = 1'b0;
            bus.m1_data_valid  = 1'b0;
            bus.m0_data_read_o = '0;
            bus.m1_data_read_o = '0;
            bus.s_r_valid      = 1'b0;
            bus.s_r_addr       = '0;
            bus.s_r_size       = '0;
            bus.s_data_ready   = 1'b0;
            busy               = 1'b0;
            gnt                = 2'b00;
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_rd_arb.sv
// Directed bench for the read arbiter; expected values are hand-derived.
module tb_ysyx_22041207_rd_arb;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam logic [63:0] A0 = 64'h8000_0000;
    localparam logic [63:0] A1 = 64'h8000_1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic       busy;
    int         n_tests = 0;
    int         n_fail  = 0;

    ysyx_22041207_rd_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ysyx_22041207_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gnt  (gnt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 2 units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        bus.m0_r_valid_i = 1'b1;  bus.m0_r_addr_i = A0; bus.m0_r_size_i = 8'h0F;
        bus.m1_r_valid_i = 1'b0;  bus.m1_r_addr_i = A1; bus.m1_r_size_i = 8'hFF;
        bus.m0_data_ready = 1'b0; bus.m1_data_ready = 1'b0;
        bus.s_r_ready = 1'b1;     bus.s_data_valid = 1'b0; bus.s_data_read = '0;

        // Reset: outputs silent even with a pending request.
        tick(); #1;
        chk("rst_m0_ready", bus.m0_r_ready_o, 0);
        chk("rst_s_r_valid", bus.s_r_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_addr", bus.s_r_addr, 0);

        // Single m0 transaction.
        tick(); rst = 1'b0; #1;
        chk("t1_m0_ready_c0", bus.m0_r_ready_o, 1);
        chk("t1_m1_ready_c0", bus.m1_r_ready_o, 0);
        chk("t1_gnt_idle", gnt, 0);
        tick(); bus.m0_r_valid_i = 1'b0; bus.s_data_valid = 1'b1;
        bus.s_data_read = 64'h1234; bus.m0_data_ready = 1'b1; #1;
        chk("t1_s_r_valid_c1", bus.s_r_valid, 1);
        chk("t1_s_r_addr", bus.s_r_addr, A0);
        chk("t1_s_r_size", bus.s_r_size, 8'h0F);
        chk("t1_gnt_addr", gnt, 2'b01);
        chk("t1_m0_ready_c1", bus.m0_r_ready_o, 0);
        chk("t1_m0_dvalid_addr", bus.m0_data_valid, 0);
        tick(); #1;
        chk("t1_m0_dvalid_c2", bus.m0_data_valid, 1);
        chk("t1_m0_data", bus.m0_data_read_o, 64'h1234);
        chk("t1_s_dready", bus.s_data_ready, 1);
        chk("t1_m1_dvalid", bus.m1_data_valid, 0);
        chk("t1_m1_data", bus.m1_data_read_o, 0);
        chk("t1_gnt_data", gnt, 2'b01);
        // Back in IDLE with s_data_valid still high: it must be ignored.
        tick(); #1;
        chk("t1_busy_idle", busy, 0);
        chk("idle_s_dready", bus.s_data_ready, 0);
        chk("idle_m0_dvalid", bus.m0_data_valid, 0);

        // Continuous contention from reset: grants alternate, m0 first.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.m0_r_valid_i = 1'b1; bus.m1_r_valid_i = 1'b1;
        bus.m1_data_ready = 1'b1; bus.s_data_read = 64'h55; #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_m0_ready", k), bus.m0_r_ready_o, (k % 2 == 0));
            chk($sformatf("rr%0d_m1_ready", k), bus.m1_r_ready_o, (k % 2 == 1));
            tick(); #1;
            chk($sformatf("rr%0d_addr", k), bus.s_r_addr, (k % 2 == 0) ? A0 : A1);
            chk($sformatf("rr%0d_held_off", k), bus.m0_r_ready_o | bus.m1_r_ready_o, 0);
            tick(); #1;
            chk($sformatf("rr%0d_m0_dvalid", k), bus.m0_data_valid, (k % 2 == 0));
            chk($sformatf("rr%0d_m1_dvalid", k), bus.m1_data_valid, (k % 2 == 1));
            tick(); #1;
        end
        // Now in IDLE with last owner m1.
        bus.m0_r_valid_i = 1'b0; bus.m1_r_valid_i = 1'b0; #1;
        chk("drop_no_ready", bus.m0_r_ready_o | bus.m1_r_ready_o, 0);
        tick(); #1;
        chk("drop_busy", busy, 0);

        // Downstream address stall for 5 cycles; m1 raised meanwhile.
        bus.s_r_ready = 1'b0; bus.s_data_valid = 1'b0; bus.m0_r_valid_i = 1'b1; #1;
        chk("st_m0_ready", bus.m0_r_ready_o, 1);
        tick(); bus.m0_r_valid_i = 1'b0; bus.m1_r_valid_i = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("st%0d_s_r_valid", k), bus.s_r_valid, 1);
            chk($sformatf("st%0d_s_r_addr", k), bus.s_r_addr, A0);
            chk($sformatf("st%0d_m1_ready", k), bus.m1_r_ready_o, 0);
            tick(); #1;
        end
        bus.s_r_ready = 1'b1; tick();
        bus.s_data_valid = 1'b1; bus.s_data_read = 64'h77; #1;
        chk("st_m0_dvalid", bus.m0_data_valid, 1);
        chk("st_m1_dvalid", bus.m1_data_valid, 0);
        tick(); #1;

        // m1 owns DATA but stalls its data_ready for 3 cycles.
        chk("m1_ready_after_wait", bus.m1_r_ready_o, 1);
        tick(); bus.m1_r_valid_i = 1'b0; bus.m1_data_ready = 1'b0;
        bus.s_data_read = 64'hABCD; #1;
        chk("m1_addr", bus.s_r_addr, A1);
        chk("m1_size", bus.s_r_size, 8'hFF);
        tick(); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dst%0d_s_dready", k), bus.s_data_ready, 0);
            chk($sformatf("dst%0d_gnt", k), gnt, 2'b10);
            chk($sformatf("dst%0d_m0_dvalid", k), bus.m0_data_valid, 0);
            tick(); #1;
        end
        bus.m1_data_ready = 1'b1; #1;
        chk("dst_s_dready", bus.s_data_ready, 1);
        chk("dst_m1_data", bus.m1_data_read_o, 64'hABCD);
        chk("dst_m0_data", bus.m0_data_read_o, 0);
        tick(); #1;
        chk("dst_busy_done", busy, 0);

        // Reset during DATA with a valid beat pending aborts the transaction.
        bus.m1_r_valid_i = 1'b1; tick(); bus.m1_r_valid_i = 1'b0; tick();
        rst = 1'b1; #1;
        chk("ab_m1_dvalid", bus.m1_data_valid, 0);
        chk("ab_s_dready", bus.s_data_ready, 0);
        tick(); rst = 1'b0; #1;
        chk("ab_busy", busy, 0);
        chk("ab_gnt", gnt, 0);
        chk("ab_s_r_valid", bus.s_r_valid, 0);
        chk("ab_m1_dvalid_after", bus.m1_data_valid, 0);
        bus.m0_r_valid_i = 1'b1; bus.m1_r_valid_i = 1'b1; #1;
        chk("ab_next_m0", bus.m0_r_ready_o, 1);
        chk("ab_next_m1", bus.m1_r_ready_o, 0);
        tick(); bus.m0_r_valid_i = 1'b0; bus.m1_r_valid_i = 1'b0; #1;
        chk("ab_next_addr", bus.s_r_addr, A0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
